// File: rtl/nes_pad_pkg.sv
// Shared constants and types for the NES pad responder: button bit positions,
// the serial frame length and the layout of the synchronised input bundle.
package nes_pad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int PAD_BITS = 8;

    typedef logic [PAD_BITS-1:0] pad_t;

    // Every asynchronous pin travels through the synchronizer as one packed word.
    typedef struct packed {
        logic       jclk;
        logic       strobe;
        logic [1:0] turbo;
        pad_t       btn;
    } pad_in_t;

endpackage

// File: rtl/pad_debounce.sv
// Single-bit debouncer: the output follows the input only after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module pad_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic out
);

    logic [15:0] cnt_q, cnt_d;
    logic        out_q, out_d;
    logic [16:0] cnt_inc;

    // One bit wider so a count reaching the top of the 16-bit range cannot wrap.
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (in != out_q) begin
            if (cnt_inc >= {1'b0, DEBOUNCE_CYCLES}) begin
                out_d = in;
            end else begin
                cnt_d = cnt_inc[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller emulation: debounced buttons with optional A/B turbo, served to
// the console through a 4021-style parallel-load / serial-shift register.
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SYNC_STAGES     = 2,
    parameter logic [23:0] TURBO_DIV       = 24'd700000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] btn_raw,
    input  logic [1:0] turbo_en,
    input  logic       joy_strobe,
    input  logic       joy_clock,
    output logic       joy_data,
    output logic [7:0] btn_state,
    output logic [3:0] shift_count
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    pad_in_t                pins;
    pad_in_t [SYNC_N-1:0]   sync_q;
    pad_in_t                sync_s;

    assign pins   = {joy_clock, joy_strobe, turbo_en, btn_raw};
    assign sync_s = sync_q[SYNC_N-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pins};
        end
    end

    generate
        for (genvar gi = 0; gi < PAD_BITS; gi++) begin : g_deb
            pad_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .in      (sync_s.btn[gi]),
                .out     (btn_state[gi])
            );
        end
    endgenerate

    logic [23:0] turbo_cnt_q, turbo_cnt_d;
    logic        turbo_phase_q, turbo_phase_d;

    always_comb begin
        turbo_cnt_d   = turbo_cnt_q + 24'd1;
        turbo_phase_d = turbo_phase_q;
        if (turbo_cnt_q >= TURBO_DIV - 24'd1) begin
            turbo_cnt_d   = '0;
            turbo_phase_d = ~turbo_phase_q;
        end
    end

    pad_t effective;

    always_comb begin
        effective = btn_state;
        if (sync_s.turbo[0]) effective[BTN_A] = btn_state[BTN_A] & turbo_phase_q;
        if (sync_s.turbo[1]) effective[BTN_B] = btn_state[BTN_B] & turbo_phase_q;
    end

    pad_t       shreg_q, shreg_d;
    logic [3:0] count_q, count_d;
    logic       jclk_prev_q;
    logic       jclk_rise;

    assign jclk_rise = sync_s.jclk & ~jclk_prev_q;

    // Load has priority over shift, so a clock edge during strobe is swallowed.
    always_comb begin
        shreg_d = shreg_q;
        count_d = count_q;
        if (sync_s.strobe) begin
            shreg_d = ~effective;
            count_d = '0;
        end else if (jclk_rise) begin
            shreg_d = {1'b0, shreg_q[PAD_BITS-1:1]};
            if (count_q < 4'(PAD_BITS)) count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
            shreg_q       <= 8'hFF;
            count_q       <= '0;
            jclk_prev_q   <= 1'b0;
        end else begin
            turbo_cnt_q   <= turbo_cnt_d;
            turbo_phase_q <= turbo_phase_d;
            shreg_q       <= shreg_d;
            count_q       <= count_d;
            jclk_prev_q   <= sync_s.jclk;
        end
    end

    assign joy_data    = shreg_q[0];
    assign shift_count = count_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder with short debounce and turbo periods,
// compared against a pin-history reference model.
module tb_nes_pad_responder;

    localparam int S  = 2;
    localparam int N  = 4;
    localparam int TD = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] btn_raw = 8'h00;
    logic [1:0] turbo_en = 2'b00;
    logic       joy_strobe = 1'b0;
    logic       joy_clock = 1'b0;
    logic       joy_data;
    logic [7:0] btn_state;
    logic [3:0] shift_count;

    int errors = 0;
    int checks = 0;

    nes_pad_responder #(
        .DEBOUNCE_CYCLES(16'd4),
        .SYNC_STAGES    (S),
        .TURBO_DIV      (24'd8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .turbo_en   (turbo_en),
        .joy_strobe (joy_strobe),
        .joy_clock  (joy_clock),
        .joy_data   (joy_data),
        .btn_state  (btn_state),
        .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    // Reference model: pins are seen S edges late; a button flips once its last N
    // seen samples all disagree; turbo phase is (edges since reset / TD) mod 2;
    // the frame is a queue of bits the console has yet to read.
    logic [11:0] pin_q[$];
    logic [7:0]  hist_q[$];
    logic        m_bits[$];
    logic [7:0]  m_state = 8'h00;
    int          m_cycles = 0;
    int          m_count = 0;
    logic        m_prev_clk = 1'b0;

    function automatic logic model_data();
        return (m_bits.size() > 0) ? m_bits[0] : 1'b0;
    endfunction

    always @(posedge clk) begin
        logic [11:0] u;
        logic [7:0]  eff;
        logic        ph;
        logic        all_diff;
        if (!reset_n) begin
            pin_q.delete();
            hist_q.delete();
            m_bits.delete();
            for (int i = 0; i < 8; i++) m_bits.push_back(1'b1);
            m_state    = 8'h00;
            m_cycles   = 0;
            m_count    = 0;
            m_prev_clk = 1'b0;
        end else begin
            u = (pin_q.size() >= S) ? pin_q[pin_q.size()-S] : 12'h000;
            pin_q.push_back({joy_clock, joy_strobe, turbo_en, btn_raw});
            if (pin_q.size() > 8) void'(pin_q.pop_front());
            ph  = ((m_cycles / TD) % 2) == 1;
            eff = m_state;
            if (u[8]) eff[0] = eff[0] & ph;
            if (u[9]) eff[1] = eff[1] & ph;
            if (u[10]) begin
                m_bits.delete();
                for (int i = 0; i < 8; i++) m_bits.push_back(~eff[i]);
                m_count = 0;
            end else if (u[11] && !m_prev_clk) begin
                if (m_bits.size() > 0) void'(m_bits.pop_front());
                if (m_count < 8) m_count++;
            end
            m_prev_clk = u[11];
            hist_q.push_back(u[7:0]);
            if (hist_q.size() > N) void'(hist_q.pop_front());
            if (hist_q.size() == N) begin
                for (int b = 0; b < 8; b++) begin
                    all_diff = 1'b1;
                    foreach (hist_q[j]) if (hist_q[j][b] == m_state[b]) all_diff = 1'b0;
                    if (all_diff) m_state[b] = ~m_state[b];
                end
            end
            m_cycles++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_pulse();
        joy_clock = 1'b1;
        cyc(2);
        joy_clock = 1'b0;
        cyc(2);
    endtask

    task automatic strobe_pulse();
        joy_strobe = 1'b1;
        cyc(2);
        joy_strobe = 1'b0;
        cyc(S + 2);
    endtask

    task automatic test_reset();
        btn_raw = 8'hFF;
        reset_n = 1'b0;
        cyc(3);
        checks++;
        if (joy_data !== 1'b1) begin errors++; $display("FAIL reset_data: got %b want 1", joy_data); end
        checks++;
        if (shift_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", shift_count); end
        checks++;
        if (btn_state !== 8'h00) begin errors++; $display("FAIL reset_btn: got %h want 00", btn_state); end
        btn_raw = 8'h00;
        reset_n = 1'b1;
        cyc(8);
        $display("test_reset: data=%b count=%0d btn=%h", joy_data, shift_count, btn_state);
    endtask

    task automatic test_serial();
        logic [7:0] exp_seq;
        exp_seq = ~8'h09;
        btn_raw = 8'h09;
        cyc(10);
        checks++;
        if (btn_state !== 8'h09) begin errors++; $display("FAIL serial_btn: got %h want 09", btn_state); end
        strobe_pulse();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (joy_data !== exp_seq[i] || joy_data !== model_data()) begin
                errors++;
                $display("FAIL serial_bit%0d: got %b want %b", i, joy_data, exp_seq[i]);
            end
            checks++;
            if (shift_count !== 4'(i)) begin errors++; $display("FAIL serial_count%0d: got %0d want %0d", i, shift_count, i); end
            $display("serial bit %0d: data=%b count=%0d", i, joy_data, shift_count);
            clock_pulse();
        end
        checks++;
        if (joy_data !== 1'b0 || shift_count !== 4'd8) begin
            errors++; $display("FAIL serial_after8: got data=%b count=%0d want 0/8", joy_data, shift_count);
        end
        clock_pulse();
        clock_pulse();
        checks++;
        if (joy_data !== 1'b0 || shift_count !== 4'd8) begin
            errors++; $display("FAIL serial_after10: got data=%b count=%0d want 0/8", joy_data, shift_count);
        end
        $display("test_serial: after 10 clocks data=%b count=%0d", joy_data, shift_count);
    endtask

    task automatic test_glitch();
        logic seen;
        btn_raw = 8'h00;
        cyc(8);
        checks++;
        if (btn_state !== 8'h00) begin errors++; $display("FAIL glitch_pre: got %h want 00", btn_state); end
        btn_raw = 8'h02;
        cyc(3);
        btn_raw = 8'h00;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checks++;
            if (btn_state !== 8'h00) begin errors++; $display("FAIL glitch3_c%0d: got %h want 00", i, btn_state); end
        end
        seen = 1'b0;
        btn_raw = 8'h02;
        cyc(4);
        btn_raw = 8'h00;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (btn_state[1]) seen = 1'b1;
            checks++;
            if (btn_state !== m_state) begin errors++; $display("FAIL glitch4_c%0d: got %h want %h", i, btn_state, m_state); end
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL glitch4_accept: got %b want 1", seen); end
        $display("test_glitch: 3-cycle rejected, 4-cycle accepted=%b", seen);
    endtask

    task automatic test_load_wins();
        btn_raw = 8'h01;
        cyc(10);
        strobe_pulse();
        clock_pulse();
        checks++;
        if (joy_data !== 1'b1 || shift_count !== 4'd1) begin
            errors++; $display("FAIL lw_pre: got data=%b count=%0d want 1/1", joy_data, shift_count);
        end
        joy_strobe = 1'b1;
        joy_clock  = 1'b1;
        cyc(S + 2);
        checks++;
        if (joy_data !== 1'b0 || shift_count !== 4'd0 || joy_data !== model_data()) begin
            errors++; $display("FAIL lw_load: got data=%b count=%0d want 0/0", joy_data, shift_count);
        end
        joy_strobe = 1'b0;
        cyc(4);
        joy_clock = 1'b0;
        cyc(3);
        checks++;
        if (shift_count !== 4'd0 || joy_data !== 1'b0) begin
            errors++; $display("FAIL lw_noshift: got data=%b count=%0d want 0/0", joy_data, shift_count);
        end
        $display("test_load_wins: data=%b count=%0d", joy_data, shift_count);
    endtask

    task automatic test_freeze();
        btn_raw = 8'h00;
        cyc(10);
        checks++;
        if (btn_state !== 8'h00) begin errors++; $display("FAIL freeze_btn: got %h want 00", btn_state); end
        checks++;
        if (joy_data !== 1'b0) begin errors++; $display("FAIL freeze_hold: got %b want 0", joy_data); end
        clock_pulse();
        checks++;
        if (joy_data !== 1'b1) begin errors++; $display("FAIL freeze_shift: got %b want 1", joy_data); end
        $display("test_freeze: data=%b count=%0d", joy_data, shift_count);
    endtask

    task automatic test_latency();
        btn_raw = 8'h02;
        cyc(10);
        for (int i = 0; i < 8; i++) clock_pulse();
        joy_strobe = 1'b1;
        cyc(S);
        checks++;
        if (joy_data !== 1'b0) begin errors++; $display("FAIL lat_strobe_early: got %b want 0", joy_data); end
        cyc(1);
        checks++;
        if (joy_data !== 1'b1) begin errors++; $display("FAIL lat_strobe: got %b want 1", joy_data); end
        joy_strobe = 1'b0;
        cyc(3);
        joy_clock = 1'b1;
        cyc(S);
        checks++;
        if (joy_data !== 1'b1) begin errors++; $display("FAIL lat_clock_early: got %b want 1", joy_data); end
        cyc(1);
        checks++;
        if (joy_data !== 1'b0) begin errors++; $display("FAIL lat_clock: got %b want 0", joy_data); end
        joy_clock = 1'b0;
        cyc(3);
        $display("test_latency: strobe and clock edges reach joy_data in %0d cycles", S + 1);
    endtask

    task automatic test_turbo();
        logic seen0, seen1;
        btn_raw  = 8'h01;
        turbo_en = 2'b00;
        cyc(10);
        strobe_pulse();
        checks++;
        if (joy_data !== 1'b0) begin errors++; $display("FAIL turbo_off: got %b want 0", joy_data); end
        turbo_en = 2'b01;
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            joy_strobe = (i % 5) == 0;
            cyc(1);
            if (joy_data) seen1 = 1'b1; else seen0 = 1'b1;
            checks++;
            if (joy_data !== model_data()) begin
                errors++; $display("FAIL turbo_c%0d: got %b want %b", i, joy_data, model_data());
            end
        end
        joy_strobe = 1'b0;
        checks++;
        if (!(seen0 && seen1)) begin errors++; $display("FAIL turbo_alt: got seen0=%b seen1=%b want 1/1", seen0, seen1); end
        turbo_en = 2'b00;
        cyc(4);
        $display("test_turbo: pressed seen=%b released seen=%b", seen0, seen1);
    endtask

    task automatic test_reset_midframe();
        btn_raw = 8'h01;
        cyc(4);
        strobe_pulse();
        for (int i = 0; i < 3; i++) clock_pulse();
        checks++;
        if (shift_count !== 4'd3) begin errors++; $display("FAIL mid_pre: got %0d want 3", shift_count); end
        reset_n = 1'b0;
        cyc(1);
        checks++;
        if (joy_data !== 1'b1 || shift_count !== 4'd0) begin
            errors++; $display("FAIL mid_reset: got data=%b count=%0d want 1/0", joy_data, shift_count);
        end
        reset_n = 1'b1;
        cyc(10);
        strobe_pulse();
        checks++;
        if (joy_data !== 1'b0 || shift_count !== 4'd0 || joy_data !== model_data()) begin
            errors++; $display("FAIL mid_reload: got data=%b count=%0d want 0/0", joy_data, shift_count);
        end
        $display("test_reset_midframe: data=%b count=%0d", joy_data, shift_count);
    endtask

    task automatic test_random();
        int frames;
        frames = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) btn_raw[$urandom_range(7)] = ~btn_raw[$urandom_range(7)];
            if ($urandom_range(2) == 0) joy_clock = ~joy_clock;
            if ($urandom_range(40) == 0) turbo_en = 2'($urandom_range(3));
            joy_strobe = ($urandom_range(30) == 0);
            if (joy_strobe) frames++;
            cyc(1);
            checks++;
            if (joy_data !== model_data()) begin
                errors++; $display("FAIL rand_data_c%0d: got %b want %b", i, joy_data, model_data());
            end
            checks++;
            if (shift_count !== 4'(m_count)) begin
                errors++; $display("FAIL rand_count_c%0d: got %0d want %0d", i, shift_count, m_count);
            end
            checks++;
            if (btn_state !== m_state) begin
                errors++; $display("FAIL rand_btn_c%0d: got %h want %h", i, btn_state, m_state);
            end
        end
        $display("test_random: 1500 cycles, %0d strobes", frames);
    endtask

    initial begin
        test_reset();
        test_serial();
        test_glitch();
        test_load_wins();
        test_freeze();
        test_latency();
        test_turbo();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
